// File: rtl/fft_bitrev_reorder_if.sv
// Stream interface for the FFT bit-reversal reorder buffer.
//   enable_in/in_re/in_im    : bit-reversed input stream from the last SDF stage
//   enable_out/out_re/out_im : natural-order output stream
//   frame_drop               : one-cycle pulse when a partial input frame is discarded
// master = stream producer/consumer side, slave = reorder buffer side.
interface fft_bitrev_reorder_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             enable_in;
    logic [WIDTH-1:0] in_re;
    logic [WIDTH-1:0] in_im;
    logic             enable_out;
    logic [WIDTH-1:0] out_re;
    logic [WIDTH-1:0] out_im;
    logic             frame_drop;

    modport master (
        output enable_in,
        output in_re,
        output in_im,
        input  enable_out,
        input  out_re,
        input  out_im,
        input  frame_drop
    );

    modport slave (
        input  enable_in,
        input  in_re,
        input  in_im,
        output enable_out,
        output out_re,
        output out_im,
        output frame_drop
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Output reorder buffer for the SDF FFT pipeline.
// Captures whole N-point frames arriving in bit-reversed order into a ping-pong
// pair of N-entry banks and replays each frame in natural order.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fft_bitrev_reorder_if.slave (input stream, output stream, frame_drop)
// Latency N+1 cycles from first input sample to natural index 0; 1 sample/cycle.
module fft_bitrev_reorder #(
    parameter int unsigned N     = 64,
    parameter int unsigned WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    fft_bitrev_reorder_if.slave  bus
);

    localparam int unsigned LOGN  = $clog2(N);
    localparam int unsigned DEPTH = 2 * N;
    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } sample_t;

    typedef enum logic {
        ST_IDLE,
        ST_READ
    } rd_state_e;

    // Reverse the LOGN-bit index.
    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int unsigned i = 0; i < LOGN; i++) begin
            r[i] = a[LOGN-1-i];
        end
        return r;
    endfunction

    // Ping-pong storage; address = {bank, index}.
    sample_t mem [DEPTH];

    logic [LOGN-1:0] wr_cnt_q;
    logic            wr_bank_q;
    logic [1:0]      bank_full_q;
    logic            frame_drop_q;

    rd_state_e       state_q, state_d;
    logic [LOGN-1:0] rd_cnt_q, rd_cnt_d;
    logic            rd_bank_q, rd_bank_d;

    logic            rd_issue_c;
    logic [1:0]      full_set_c;
    logic [1:0]      full_clr_c;
    logic            wr_last_c;

    logic            enable_out_q;
    sample_t         out_q;

    assign wr_last_c = bus.enable_in && (wr_cnt_q == LAST_IDX);

    // Input sample k of a frame lands at address k of the write bank.
    always_ff @(posedge clk) begin
        if (bus.enable_in) begin
            mem[{wr_bank_q, wr_cnt_q}] <= sample_t'{re: bus.in_re, im: bus.in_im};
        end
    end

    // Write counter, bank select and partial-frame discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q     <= '0;
            wr_bank_q    <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            frame_drop_q <= 1'b0;
            if (bus.enable_in) begin
                wr_cnt_q <= wr_cnt_q + LOGN'(1);
                if (wr_last_c) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end else if (wr_cnt_q != '0) begin
                wr_cnt_q     <= '0;
                frame_drop_q <= 1'b1;
            end
        end
    end

    // Set and clear always target different banks, so a plain OR/AND-NOT is safe.
    always_comb begin
        full_set_c = 2'b00;
        if (wr_last_c) begin
            full_set_c[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full_q <= 2'b00;
        end else begin
            bank_full_q <= (bank_full_q | full_set_c) & ~full_clr_c;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Read FSM next state; chains straight into the other bank when it is already full.
    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_bank_d  = rd_bank_q;
        rd_issue_c = 1'b0;
        full_clr_c = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d  = ST_READ;
                    rd_cnt_d = '0;
                end
            end
            ST_READ: begin
                rd_issue_c = 1'b1;
                rd_cnt_d   = rd_cnt_q + LOGN'(1);
                if (rd_cnt_q == LAST_IDX) begin
                    full_clr_c[rd_bank_q] = 1'b1;
                    rd_bank_d             = ~rd_bank_q;
                    if (!bank_full_q[~rd_bank_q]) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One register of read latency; data holds when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_out_q <= 1'b0;
            out_q        <= '0;
        end else begin
            enable_out_q <= rd_issue_c;
            if (rd_issue_c) begin
                out_q <= mem[{rd_bank_q, bitrev(rd_cnt_q)}];
            end
        end
    end

    assign bus.enable_out = enable_out_q;
    assign bus.out_re     = out_q.re;
    assign bus.out_im     = out_q.im;
    assign bus.frame_drop = frame_drop_q;

endmodule
